// File: rtl/rvga_mem_arbiter_pkg.sv
// Shared types for the memory arbiter and its byte-merge helper.
package rvga_mem_arbiter_pkg;

    localparam int WORD_W = 32;
    localparam int MASK_W = WORD_W / 8;

    typedef logic [WORD_W-1:0] rvga_word;
    typedef logic [7:0]        rvga_byte;
    typedef logic [MASK_W-1:0] rvga_mask;

    // Arbiter sequencing; DONE and RMW_GAP are the idle-request cycles on DDR.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_I_RD,
        ST_D_RD,
        ST_D_WR,
        ST_RMW_RD,
        ST_RMW_GAP,
        ST_RMW_WR,
        ST_DONE
    } arb_state_e;

    typedef enum logic {
        GRANT_IMEM,
        GRANT_DMEM
    } grant_e;

endpackage

// File: rtl/rvga_byte_merge.sv
// Combinational masked merge: bytes with mask bit set come from new_word,
// the rest from old_word.
module rvga_byte_merge #(
    parameter int MASK_W = 4
) (
    input  logic [MASK_W*8-1:0] old_word,
    input  logic [MASK_W*8-1:0] new_word,
    input  logic [MASK_W-1:0]   mask,
    output logic [MASK_W*8-1:0] merged
);

    // Byte-wise select between the stored and the incoming word.
    always_comb begin
        // NOTE: give every combinational output a default first so no path leaves it unassigned (which would infer a latch).
        merged = old_word;
        for (int i = 0; i < MASK_W; i++) begin
            if (mask[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/rvga_mem_arbiter.sv
// Two-port (fetch + data) to single DDR word-port arbiter with
// read-modify-write for byte-masked data writes.
module rvga_mem_arbiter
    import rvga_mem_arbiter_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int MASK_W = WORD_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] imem_addr,
    input  logic              imem_read,
    output logic [WORD_W-1:0] imem_rdata,
    output logic              imem_resp,
    input  logic [WORD_W-1:0] dmem_addr,
    input  logic              dmem_read,
    input  logic              dmem_write,
    input  logic [MASK_W-1:0] dmem_wmask,
    input  logic [WORD_W-1:0] dmem_wdata,
    output logic [WORD_W-1:0] dmem_rdata,
    output logic              dmem_resp,
    output logic [WORD_W-1:0] ddr_addr,
    output logic              ddr_read,
    output logic              ddr_write,
    output logic [WORD_W-1:0] ddr_wdata,
    input  logic [WORD_W-1:0] ddr_rdata,
    input  logic              ddr_resp
);

    localparam logic [WORD_W-1:0] ALIGN_MASK = {{(WORD_W-2){1'b1}}, 2'b00};

    arb_state_e        state_q, state_d;
    grant_e            last_grant_q, last_grant_d;
    grant_e            grant_q, grant_d;
    logic [WORD_W-1:0] ddr_addr_q, ddr_addr_d;
    logic [WORD_W-1:0] ddr_wdata_q, ddr_wdata_d;
    logic [WORD_W-1:0] imem_rdata_q, imem_rdata_d;
    logic [WORD_W-1:0] dmem_rdata_q, dmem_rdata_d;
    logic [WORD_W-1:0] rmw_merged;
    logic              imem_pend;
    logic              dmem_pend;
    logic              pick_dmem;

    assign imem_pend = imem_read;
    assign dmem_pend = dmem_read | dmem_write;
    // With both pending, the port that did not win last time goes first.
    assign pick_dmem = dmem_pend & (~imem_pend | (last_grant_q == GRANT_IMEM));

    rvga_byte_merge #(.MASK_W(MASK_W)) u_merge (
        .old_word (ddr_rdata),
        .new_word (dmem_wdata),
        .mask     (dmem_wmask),
        .merged   (rmw_merged)
    );

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GRANT_IMEM;
            grant_q      <= GRANT_IMEM;
            ddr_addr_q   <= '0;
            ddr_wdata_q  <= '0;
            imem_rdata_q <= '0;
            dmem_rdata_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            ddr_addr_q   <= ddr_addr_d;
            ddr_wdata_q  <= ddr_wdata_d;
            imem_rdata_q <= imem_rdata_d;
            dmem_rdata_q <= dmem_rdata_d;
        end
    end

    // Next-state: arbitration in IDLE, DDR handshake tracking elsewhere.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        ddr_addr_d   = ddr_addr_q;
        ddr_wdata_d  = ddr_wdata_q;
        imem_rdata_d = imem_rdata_q;
        dmem_rdata_d = dmem_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_dmem) begin
                    grant_d      = GRANT_DMEM;
                    last_grant_d = GRANT_DMEM;
                    ddr_addr_d   = dmem_addr & ALIGN_MASK;
                    ddr_wdata_d  = dmem_wdata;
                    if (dmem_read) begin
                        state_d = ST_D_RD;
                    end else if (dmem_wmask == '1) begin
                        state_d = ST_D_WR;
                    end else if (dmem_wmask == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RMW_RD;
                    end
                end else if (imem_pend) begin
                    grant_d      = GRANT_IMEM;
                    last_grant_d = GRANT_IMEM;
                    ddr_addr_d   = imem_addr & ALIGN_MASK;
                    state_d      = ST_I_RD;
                end
            end
            ST_I_RD: begin
                if (ddr_resp) begin
                    imem_rdata_d = ddr_rdata;
                    state_d      = ST_DONE;
                end
            end
            ST_D_RD: begin
                if (ddr_resp) begin
                    dmem_rdata_d = ddr_rdata;
                    state_d      = ST_DONE;
                end
            end
            ST_D_WR, ST_RMW_WR: begin
                if (ddr_resp) begin
                    state_d = ST_DONE;
                end
            end
            ST_RMW_RD: begin
                if (ddr_resp) begin
                    ddr_wdata_d = rmw_merged;
                    state_d     = ST_RMW_GAP;
                end
            end
            ST_RMW_GAP: state_d = ST_RMW_WR;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state so reset clears them immediately.
    always_comb begin
        ddr_read  = (state_q == ST_I_RD) || (state_q == ST_D_RD) || (state_q == ST_RMW_RD);
        ddr_write = (state_q == ST_D_WR) || (state_q == ST_RMW_WR);
        imem_resp = (state_q == ST_DONE) && (grant_q == GRANT_IMEM);
        dmem_resp = (state_q == ST_DONE) && (grant_q == GRANT_DMEM);
    end

    assign ddr_addr   = ddr_addr_q;
    assign ddr_wdata  = ddr_wdata_q;
    assign imem_rdata = imem_rdata_q;
    assign dmem_rdata = dmem_rdata_q;

endmodule

// File: tb/tb_rvga_mem_arbiter.sv
// Directed bench for rvga_mem_arbiter with a small DDR responder model.
module tb_rvga_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic        imem_read;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic [31:0] dmem_addr;
    logic        dmem_read;
    logic        dmem_write;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic [31:0] ddr_addr;
    logic        ddr_read;
    logic        ddr_write;
    logic [31:0] ddr_wdata;
    logic [31:0] ddr_rdata;
    logic        ddr_resp;

    int tests_run = 0;
    int tests_failed = 0;

    rvga_mem_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_read  (imem_read),
        .imem_rdata (imem_rdata),
        .imem_resp  (imem_resp),
        .dmem_addr  (dmem_addr),
        .dmem_read  (dmem_read),
        .dmem_write (dmem_write),
        .dmem_wmask (dmem_wmask),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_resp  (dmem_resp),
        .ddr_addr   (ddr_addr),
        .ddr_read   (ddr_read),
        .ddr_write  (ddr_write),
        .ddr_wdata  (ddr_wdata),
        .ddr_rdata  (ddr_rdata),
        .ddr_resp   (ddr_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        iresp;
        logic        dresp;
    } cyc_t;

    cyc_t        log_q[$];
    byte         order_q[$];
    logic [31:0] mem [0:255];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Per-cycle record of DUT outputs, sampled just after the rising edge.
    initial begin
        cyc_t c;
        forever begin
            @(posedge clk);
            #1;
            c.rd    = ddr_read;
            c.wr    = ddr_write;
            c.addr  = ddr_addr;
            c.wdata = ddr_wdata;
            c.iresp = imem_resp;
            c.dresp = dmem_resp;
            log_q.push_back(c);
            if (imem_resp) order_q.push_back(8'h49);
            if (dmem_resp) order_q.push_back(8'h44);
        end
    end

    // DDR responder: answers each request after a short wait with a one-cycle pulse.
    initial begin
        int cnt;
        cnt = 0;
        ddr_resp  = 1'b0;
        ddr_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ddr_resp = 1'b0;
                cnt = 0;
            end else if (ddr_resp) begin
                ddr_resp = 1'b0;
            end else if (ddr_read || ddr_write) begin
                if (cnt >= 2) begin
                    cnt = 0;
                    if (ddr_write) mem[ddr_addr[9:2]] = ddr_wdata;
                    else           ddr_rdata = mem[ddr_addr[9:2]];
                    ddr_resp = 1'b1;
                end else begin
                    cnt++;
                end
            end
        end
    end

    function automatic int rises(input bit wr_sel);
        int n = 0;
        for (int i = 0; i < log_q.size(); i++) begin
            logic cur, prev;
            cur  = wr_sel ? log_q[i].wr : log_q[i].rd;
            prev = (i == 0) ? 1'b0 : (wr_sel ? log_q[i-1].wr : log_q[i-1].rd);
            if (cur && !prev) n++;
        end
        return n;
    endfunction

    function automatic int first_rise(input bit wr_sel);
        for (int i = 0; i < log_q.size(); i++) begin
            if (wr_sel ? log_q[i].wr : log_q[i].rd) return i;
        end
        return -1;
    endfunction

    function automatic int resp_count(input bit d_sel);
        int n = 0;
        for (int i = 0; i < log_q.size(); i++) begin
            if (d_sel ? log_q[i].dresp : log_q[i].iresp) n++;
        end
        return n;
    endfunction

    function automatic int first_resp(input bit d_sel);
        for (int i = 0; i < log_q.size(); i++) begin
            if (d_sel ? log_q[i].dresp : log_q[i].iresp) return i;
        end
        return -1;
    endfunction

    function automatic int both_high();
        int n = 0;
        for (int i = 0; i < log_q.size(); i++) begin
            if (log_q[i].rd && log_q[i].wr) n++;
        end
        return n;
    endfunction

    task automatic clear_log();
        log_q.delete();
        order_q.delete();
    endtask

    task automatic check_outputs_zero(input string pfx);
        check({pfx, "_ddr_read"},   {31'd0, ddr_read},  32'd0);
        check({pfx, "_ddr_write"},  {31'd0, ddr_write}, 32'd0);
        check({pfx, "_imem_resp"},  {31'd0, imem_resp}, 32'd0);
        check({pfx, "_dmem_resp"},  {31'd0, dmem_resp}, 32'd0);
        check({pfx, "_ddr_addr"},   ddr_addr,   32'd0);
        check({pfx, "_ddr_wdata"},  ddr_wdata,  32'd0);
        check({pfx, "_imem_rdata"}, imem_rdata, 32'd0);
        check({pfx, "_dmem_rdata"}, dmem_rdata, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic imem_req(input logic [31:0] a, output logic [31:0] rdata, output int lat);
        imem_addr = a;
        imem_read = 1'b1;
        lat = 0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (imem_resp) break;
        end
        check("imem_resp_seen", {31'd0, imem_resp}, 32'd1);
        rdata = imem_rdata;
        imem_read = 1'b0;
    endtask

    task automatic dmem_req(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [3:0] m, input logic [31:0] wd, input bit drop,
                            output logic [31:0] rdata, output int lat);
        dmem_addr  = a;
        dmem_read  = rd;
        dmem_write = wr;
        dmem_wmask = m;
        dmem_wdata = wd;
        lat = 0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (dmem_resp) break;
        end
        check("dmem_resp_seen", {31'd0, dmem_resp}, 32'd1);
        rdata = dmem_rdata;
        if (drop) begin
            dmem_read  = 1'b0;
            dmem_write = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] rd_i, rd_d, rd_d2;
        int lat_i, lat_d, w, r, k;
        bit found;
        logic prev_rd;

        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h04] = 32'h1122_3344;
        mem[8'h10] = 32'hAABB_CCDD;

        rst = 1'b1;
        imem_addr = '0; imem_read = 1'b0;
        dmem_addr = '0; dmem_read = 1'b0; dmem_write = 1'b0;
        dmem_wmask = '0; dmem_wdata = '0;
        #1;
        check_outputs_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single fetch.
        clear_log();
        imem_req(32'h0000_0010, rd_i, lat_i);
        repeat (3) @(negedge clk);
        check("fetch_rdata", rd_i, 32'h1122_3344);
        check("fetch_rd_count", rises(1'b0), 1);
        check("fetch_wr_count", rises(1'b1), 0);
        r = first_rise(1'b0);
        check("fetch_addr", (r >= 0) ? log_q[r].addr : 32'hFFFF_FFFF, 32'h10);
        check("fetch_iresp_count", resp_count(1'b0), 1);
        check("fetch_dresp_count", resp_count(1'b1), 0);
        k = first_resp(1'b0);
        check("fetch_resp_after_rd", (k >= 1) ? {31'd0, log_q[k-1].rd} : 32'd0, 32'd1);
        check("fetch_rdata_hold", imem_rdata, 32'h1122_3344);

        // Full-word write to an unaligned address.
        clear_log();
        dmem_req(1'b0, 1'b1, 32'h23, 4'hF, 32'hDEAD_BEEF, 1'b1, rd_d, lat_d);
        repeat (3) @(negedge clk);
        check("fullwr_wr_count", rises(1'b1), 1);
        check("fullwr_rd_count", rises(1'b0), 0);
        w = first_rise(1'b1);
        check("fullwr_addr", (w >= 0) ? log_q[w].addr : 32'hFFFF_FFFF, 32'h20);
        check("fullwr_wdata", (w >= 0) ? log_q[w].wdata : 32'hFFFF_FFFF, 32'hDEAD_BEEF);
        check("fullwr_dresp_count", resp_count(1'b1), 1);
        check("fullwr_mem", mem[8'h08], 32'hDEAD_BEEF);

        // Partial write through read-modify-write.
        clear_log();
        dmem_req(1'b0, 1'b1, 32'h40, 4'b0101, 32'h1122_3344, 1'b1, rd_d, lat_d);
        repeat (3) @(negedge clk);
        check("rmw_rd_count", rises(1'b0), 1);
        check("rmw_wr_count", rises(1'b1), 1);
        w = first_rise(1'b1);
        check("rmw_wr_seen", {31'd0, w >= 2}, 32'd1);
        if (w >= 2) begin
            check("rmw_gap_low", {30'd0, log_q[w-1].rd, log_q[w-1].wr}, 32'd0);
            check("rmw_rd_before_gap", {31'd0, log_q[w-2].rd}, 32'd1);
            check("rmw_wdata", log_q[w].wdata, 32'hAA22_CC44);
            check("rmw_addr", log_q[w].addr, 32'h40);
        end
        k = first_resp(1'b1);
        check("rmw_resp_after_wr", {31'd0, k > w}, 32'd1);
        check("rmw_mem", mem[8'h10], 32'hAA22_CC44);

        // Zero-mask write: immediate completion, no DDR traffic.
        clear_log();
        dmem_req(1'b0, 1'b1, 32'h80, 4'h0, 32'h5555_AAAA, 1'b1, rd_d, lat_d);
        repeat (3) @(negedge clk);
        check("zmask_latency_le2", {31'd0, lat_d <= 2}, 32'd1);
        check("zmask_rd_count", rises(1'b0), 0);
        check("zmask_wr_count", rises(1'b1), 0);
        check("zmask_dresp_count", resp_count(1'b1), 1);

        // Contention straight after reset: dmem, then imem, then dmem again.
        do_reset();
        clear_log();
        fork
            imem_req(32'h0000_0010, rd_i, lat_i);
            begin
                dmem_req(1'b1, 1'b0, 32'h40, 4'h0, 32'h0, 1'b0, rd_d, lat_d);
                dmem_req(1'b1, 1'b0, 32'h22, 4'h0, 32'h0, 1'b1, rd_d2, lat_d);
            end
        join
        repeat (3) @(negedge clk);
        check("cont_resp_count", order_q.size(), 3);
        if (order_q.size() == 3) begin
            check("cont_first_dmem",  {24'd0, order_q[0]}, 32'h44);
            check("cont_second_imem", {24'd0, order_q[1]}, 32'h49);
            check("cont_third_dmem",  {24'd0, order_q[2]}, 32'h44);
        end
        check("cont_imem_rdata", rd_i, 32'h1122_3344);
        check("cont_dmem_rdata1", rd_d, 32'hAA22_CC44);
        check("cont_dmem_rdata2", rd_d2, 32'hDEAD_BEEF);
        check("cont_no_rd_wr_overlap", both_high(), 0);

        // Reset asserted during the RMW gap cycle.
        clear_log();
        dmem_addr = 32'h40; dmem_read = 1'b0; dmem_write = 1'b1;
        dmem_wmask = 4'b0011; dmem_wdata = 32'h0BAD_F00D;
        found = 1'b0;
        prev_rd = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (prev_rd && !ddr_read && !ddr_write) begin
                found = 1'b1;
                break;
            end
            prev_rd = ddr_read;
        end
        check("rmwrst_gap_found", {31'd0, found}, 32'd1);
        rst = 1'b1;
        #1;
        check_outputs_zero("rmwrst");
        dmem_write = 1'b0;
        dmem_wmask = 4'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_log();
        fork
            imem_req(32'h0000_0010, rd_i, lat_i);
            dmem_req(1'b1, 1'b0, 32'h40, 4'h0, 32'h0, 1'b1, rd_d, lat_d);
        join
        repeat (3) @(negedge clk);
        check("rmwrst_resp_count", order_q.size(), 2);
        if (order_q.size() >= 1) check("rmwrst_first_dmem", {24'd0, order_q[0]}, 32'h44);
        check("rmwrst_mem_untouched", rd_d, 32'hAA22_CC44);
        check("rmwrst_no_rd_wr_overlap", both_high(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/rvga_mem_arbiter.md
Name: rvga_mem_arbiter

Overview:
- Two-port to single-port memory arbiter that sits directly upstream of the DDR word port and is its only driver.
- It merges the instruction-fetch port (read-only) and the data port (read/write with byte mask) onto the one DDR word interface.
- Byte-masked data writes are implemented as read-modify-write, because the DDR port writes whole words only.

Parameters:
- WORD_W, 32, data/address width (matches rvga_word).
- MASK_W, 4, byte-enable width (WORD_W/8).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- imem_addr  in  32  fetch address.
- imem_read  in  1  fetch request; held until imem_resp.
- imem_rdata  out  32  fetch data; valid while imem_resp=1.
- imem_resp  out  1  one-cycle completion pulse.
- dmem_addr  in  32  data address.
- dmem_read  in  1  data read request; held until dmem_resp.
- dmem_write  in  1  data write request; held until dmem_resp. Never asserted together with dmem_read.
- dmem_wmask  in  4  byte enables; bit i covers dmem_wdata[8i+7:8i].
- dmem_wdata  in  32  write data.
- dmem_rdata  out  32  read data; valid while dmem_resp=1.
- dmem_resp  out  1  one-cycle completion pulse.
- ddr_addr  out  32  word address to DDR; bits [1:0] always 0.
- ddr_read  out  1  DDR read request.
- ddr_write  out  1  DDR write request.
- ddr_wdata  out  32  DDR write data.
- ddr_rdata  in  32  DDR read data; valid with ddr_resp.
- ddr_resp  in  1  DDR completion pulse.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - All outputs 0: ddr_read, ddr_write, imem_resp, dmem_resp, ddr_addr, ddr_wdata, imem_rdata, dmem_rdata.
  - last_grant=IMEM.
  - Reset mid-transaction abandons it; no response is issued. Requesters must re-request after reset.
- States: IDLE, I_RD, D_RD, D_WR, RMW_RD, RMW_GAP, RMW_WR, DONE.
- DDR handshake:
  - ddr_read/ddr_write are decoded from state only: read in I_RD, D_RD, RMW_RD; write in D_WR, RMW_WR.
  - ddr_addr and ddr_wdata are registered and stable for the whole request.
  - The request stays asserted until ddr_resp is sampled high.
  - Request lines are low for at least one cycle between consecutive DDR transactions. DONE and RMW_GAP provide this gap.
- IDLE arbitration, one grant per cycle:
  - Only imem pending -> I_RD.
  - Only dmem pending -> dmem path.
  - Both pending -> grant the port not in last_grant. last_grant updates on grant.
- Dmem path:
  - read -> D_RD.
  - write with wmask=4'hF -> D_WR.
  - write with wmask=4'h0 -> DONE directly; no DDR traffic.
  - any other mask -> RMW_RD.
- Address capture: on grant, addr & ~32'h3 is latched into ddr_addr.
- I_RD/D_RD on ddr_resp: ddr_rdata is latched into the granted port's rdata register -> DONE.
- D_WR on ddr_resp -> DONE.
- RMW_RD on ddr_resp -> RMW_GAP. Merge: ddr_wdata[8i+7:8i] = wmask[i] ? dmem_wdata byte i : ddr_rdata byte i.
- RMW_GAP -> RMW_WR unconditionally; the request lines are low for this cycle.
- RMW_WR on ddr_resp -> DONE.
- DONE:
  - Pulse the granted port's resp for exactly one cycle.
  - rdata holds its value until the next response on that port.
  - DONE -> IDLE.
- A requester drops or changes its request in the cycle after its resp. IDLE is the first cycle a new request is considered, so there is no double-issue.
- A DDR error response does not exist; ddr_resp is the only completion.
- ddr_resp outside the I_RD, D_RD, D_WR, RMW_RD and RMW_WR states is ignored.

Decomposition:
- Shared package / rvga_types.vh:
  - rvga_word, rvga_byte, a new rvga_mask (4-bit) typedef.
  - An arbiter state enum.
  - A grant enum {GRANT_IMEM, GRANT_DMEM}.
- One sub-module: rvga_byte_merge, a combinational masked merge of old word, new word and mask. It is reused later by the data cache.

Test Plan:
- Single fetch: imem_addr=32'h0000_0010, imem_read=1; DDR returns 32'h1122_3344 -> ddr_read with ddr_addr=32'h10; imem_resp one pulse, one cycle after ddr_resp; imem_rdata=32'h1122_3344; no dmem_resp.
- Full-word write: dmem_addr=32'h23, wmask=4'hF, wdata=32'hDEAD_BEEF -> one ddr_write, ddr_addr=32'h20, ddr_wdata=32'hDEAD_BEEF, no ddr_read; dmem_resp one pulse.
- Partial write RMW: memory word 32'hAABB_CCDD at 32'h40; wmask=4'b0101, wdata=32'h1122_3344 -> ddr_read, then one cycle with read and write both low, then ddr_write with wdata=32'hAA22_CC44; dmem_resp only after the write.
- Contention: imem and dmem assert in the same cycle after reset -> dmem served first, then imem. Repeat both -> imem first. No cycle has ddr_read and ddr_write both high.
- Zero-mask write: wmask=4'h0 -> dmem_resp within 2 cycles; ddr_read and ddr_write stay 0 throughout.
- Reset mid-RMW: assert rst during RMW_GAP -> all outputs 0 in the same cycle (async). After release, the IDLE grant order starts with dmem (last_grant=IMEM).
